// File: rtl/mem_arbiter_2to1.sv
// rtl/mem_arbiter_2to1.sv - two-port round-robin arbiter in front of a single memory controller
//
// Purpose: grants one of two requesters (port 0 = icache, port 1 = dcache)
// access to the memory controller, latches the granted request, and returns
// a one-cycle completion (or timeout abort) pulse to the owning port.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/rw/addr/wdata   per-port request (index 0 icache, 1 dcache)
//   resp_ready/resp_err       per-port completion pulse and abort flag
//   resp_rdata                shared read data, valid with resp_ready
//   mem_valid/rw/addr/wdata   request to the memory controller
//   mem_ready/mem_rdata       memory controller completion and read data
`timescale 1ns/1ps
module mem_arbiter_2to1 #(
  parameter int ADDR_W  = 20,
  parameter int LINE_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_rw,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][LINE_W-1:0] req_wdata,
  output logic [1:0]             resp_ready,
  output logic [1:0]             resp_err,
  output logic [LINE_W-1:0]      resp_rdata,
  output logic                   mem_valid,
  output logic                   mem_rw,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [LINE_W-1:0]      mem_wdata,
  input  logic                   mem_ready,
  input  logic [LINE_W-1:0]      mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                lat_rw_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [LINE_W-1:0]   lat_wdata_q;

  logic                grant;
  logic                take;
  logic                owner;

  // The memory side only ever sees the latched copy, so requesters may
  // change their fields while a transaction is in flight.
  assign mem_rw    = lat_rw_q;
  assign mem_addr  = lat_addr_q;
  assign mem_wdata = lat_wdata_q;

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    take       = 1'b0;
    owner      = (state_q == BUSY1);
    mem_valid  = 1'b0;
    resp_ready = 2'b00;
    resp_err   = 2'b00;
    resp_rdata = '0;

    case (state_q)
      IDLE: begin
        take = |req_valid;
        case (req_valid)
          2'b01:   grant = 1'b0;
          2'b10:   grant = 1'b1;
          // On a tie the port that did not win last time goes first.
          2'b11:   grant = ~last_grant_q;
          default: grant = 1'b0;
        endcase
        if (take) begin
          state_d = grant ? BUSY1 : BUSY0;
        end
      end

      BUSY0, BUSY1: begin
        mem_valid = 1'b1;
        // A completion in the timeout cycle still counts as a normal one.
        if (mem_ready) begin
          resp_ready[owner] = 1'b1;
          resp_rdata        = mem_rdata;
          state_d           = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          resp_ready[owner] = 1'b1;
          resp_err[owner]   = 1'b1;
          state_d           = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // While reset is held the block is quiet, so an in-flight transaction
    // is abandoned without a response.
    if (rst) begin
      mem_valid  = 1'b0;
      resp_ready = 2'b00;
      resp_err   = 2'b00;
      resp_rdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      lat_rw_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (take) begin
          last_grant_q <= grant;
          cnt_q        <= '0;
          lat_rw_q     <= req_rw[grant];
          lat_addr_q   <= req_addr[grant];
          lat_wdata_q  <= req_wdata[grant];
        end
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// tb/tb_mem_arbiter_2to1.sv - self-checking bench for mem_arbiter_2to1
`timescale 1ns/1ps
module tb_mem_arbiter_2to1;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid, req_rw;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][DW-1:0]  req_wdata;
  logic [1:0]          resp_ready, resp_err;
  logic [DW-1:0]       resp_rdata;
  logic                mem_valid, mem_rw;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_ready;
  logic [DW-1:0]       mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_2to1 #(.ADDR_W(AW), .LINE_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_ready(resp_ready), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic          rst;
    logic [1:0]    v;
    logic [1:0]    rw;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          mr;
    logic [DW-1:0] mrd;
    logic          e_mv;
    logic          e_mrw;
    logic [AW-1:0] e_ma;
    logic [DW-1:0] e_mwd;
    logic [1:0]    e_rr, e_re;
    logic [DW-1:0] e_rd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [1:0] rw,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic mr, input logic [DW-1:0] mrd,
                              input logic e_mv, input logic e_mrw, input logic [AW-1:0] e_ma,
                              input logic [DW-1:0] e_mwd, input logic [1:0] e_rr,
                              input logic [1:0] e_re, input logic [DW-1:0] e_rd);
    vec_t t;
    t.rst = r; t.v = v; t.rw = rw; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.mr = mr; t.mrd = mrd; t.e_mv = e_mv; t.e_mrw = e_mrw; t.e_ma = e_ma;
    t.e_mwd = e_mwd; t.e_rr = e_rr; t.e_re = e_re; t.e_rd = e_rd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: who owns the memory, how many BUSY cycles have gone by
  // without an answer, who won last, and the captured request.
  int            m_owner, m_elapsed, m_last;
  logic          m_rw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          x_mv;
  logic [1:0]    x_rr, x_re;
  logic [DW-1:0] x_rd;

  task automatic model_expect();
    x_mv = 1'b0; x_rr = 2'b00; x_re = 2'b00; x_rd = '0;
    if (!rst && m_owner >= 0) begin
      x_mv = 1'b1;
      if (mem_ready) begin
        x_rr[m_owner] = 1'b1;
        x_rd = mem_rdata;
      end else if (m_elapsed == TO) begin
        x_rr[m_owner] = 1'b1;
        x_re[m_owner] = 1'b1;
      end
    end
  endtask

  task automatic model_step();
    int w;
    if (rst) begin
      m_owner = -1; m_last = 1; m_elapsed = 0;
    end else if (m_owner < 0) begin
      if (req_valid != 2'b00) begin
        if (req_valid == 2'b11) w = 1 - m_last;
        else w = req_valid[1] ? 1 : 0;
        m_owner = w; m_last = w; m_elapsed = 0;
        m_rw = req_rw[w]; m_addr = req_addr[w]; m_wdata = req_wdata[w];
      end
    end else if (x_rr != 2'b00) begin
      m_owner = -1;
    end else begin
      m_elapsed++;
    end
  endtask

  vec_t vec[43];

  initial begin
    logic [1:0] need_new;

    // rst v rw a0 a1 d0 d1 mr mrd | mv mrw ma mwd rr re rd
    vec[0]  = mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 2'b00, 2'b00, 0);
    vec[1]  = mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 32'h1,         0, 0, 0, 0, 2'b00, 2'b00, 0);
    vec[2]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 2'b00, 2'b00, 0);
    // single read, answered in the fourth BUSY cycle
    vec[3]  = mk(0, 2'b01, 2'b00, 20'h00010, 0, 0, 0, 0, 0,     0, 0, 0, 0, 2'b00, 2'b00, 0);
    vec[4]  = mk(0, 2'b01, 2'b00, 20'h00010, 0, 0, 0, 0, 0,     1, 0, 20'h00010, 0, 2'b00, 2'b00, 0);
    vec[5]  = mk(0, 2'b01, 2'b00, 20'h00010, 0, 0, 0, 0, 0,     1, 0, 20'h00010, 0, 2'b00, 2'b00, 0);
    vec[6]  = mk(0, 2'b01, 2'b00, 20'h00010, 0, 0, 0, 0, 0,     1, 0, 20'h00010, 0, 2'b00, 2'b00, 0);
    vec[7]  = mk(0, 2'b01, 2'b00, 20'h00010, 0, 0, 0, 1, 32'hDEADBEEF, 1, 0, 20'h00010, 0, 2'b01, 2'b00, 32'hDEADBEEF);
    vec[8]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 2'b00, 2'b00, 0);
    // tie from reset: 0, 1, 0
    vec[9]  = mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 2'b00, 2'b00, 0);
    vec[10] = mk(0, 2'b11, 2'b00, 20'h100, 20'h200, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    vec[11] = mk(0, 2'b11, 2'b00, 20'h100, 20'h200, 0, 0, 1, 32'hA0, 1, 0, 20'h100, 0, 2'b01, 2'b00, 32'hA0);
    vec[12] = mk(0, 2'b11, 2'b00, 20'h100, 20'h200, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    vec[13] = mk(0, 2'b11, 2'b00, 20'h100, 20'h200, 0, 0, 1, 32'hB1, 1, 0, 20'h200, 0, 2'b10, 2'b00, 32'hB1);
    vec[14] = mk(0, 2'b11, 2'b00, 20'h100, 20'h200, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    vec[15] = mk(0, 2'b11, 2'b00, 20'h100, 20'h200, 0, 0, 1, 32'hC2, 1, 0, 20'h100, 0, 2'b01, 2'b00, 32'hC2);
    // port 1 write; its fields change during BUSY without reaching memory
    vec[16] = mk(0, 2'b10, 2'b10, 0, 20'h0FFFF, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    vec[17] = mk(0, 2'b10, 2'b10, 0, 20'h0FFFF, 0, 32'hCAFEF00D, 0, 0, 1, 1, 20'h0FFFF, 32'h12345678, 2'b00, 2'b00, 0);
    vec[18] = mk(0, 2'b10, 2'b00, 0, 20'h00001, 0, 32'h0BADBEEF, 0, 0, 1, 1, 20'h0FFFF, 32'h12345678, 2'b00, 2'b00, 0);
    vec[19] = mk(0, 2'b10, 2'b10, 0, 20'h0FFFF, 0, 32'h12345678, 1, 32'h55, 1, 1, 20'h0FFFF, 32'h12345678, 2'b10, 2'b00, 32'h55);
    vec[20] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 2'b00, 2'b00, 0);
    // stray mem_ready in IDLE
    vec[21] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 32'h77,        0, 0, 0, 0, 2'b00, 2'b00, 0);
    vec[22] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 2'b00, 2'b00, 0);
    // timeout on port 0: four silent BUSY cycles, then the abort pulse
    vec[23] = mk(0, 2'b01, 2'b00, 20'h3, 0, 0, 0, 0, 0,         0, 0, 0, 0, 2'b00, 2'b00, 0);
    vec[24] = mk(0, 2'b01, 2'b00, 20'h3, 0, 0, 0, 0, 0,         1, 0, 20'h3, 0, 2'b00, 2'b00, 0);
    vec[25] = mk(0, 2'b01, 2'b00, 20'h3, 0, 0, 0, 0, 0,         1, 0, 20'h3, 0, 2'b00, 2'b00, 0);
    vec[26] = mk(0, 2'b01, 2'b00, 20'h3, 0, 0, 0, 0, 0,         1, 0, 20'h3, 0, 2'b00, 2'b00, 0);
    vec[27] = mk(0, 2'b01, 2'b00, 20'h3, 0, 0, 0, 0, 0,         1, 0, 20'h3, 0, 2'b00, 2'b00, 0);
    vec[28] = mk(0, 2'b01, 2'b00, 20'h3, 0, 0, 0, 0, 32'hEE,    1, 0, 20'h3, 0, 2'b01, 2'b01, 0);
    vec[29] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 2'b00, 2'b00, 0);
    // mem_ready in the timeout cycle is a normal completion
    vec[30] = mk(0, 2'b10, 2'b00, 0, 20'h4, 0, 0, 0, 0,         0, 0, 0, 0, 2'b00, 2'b00, 0);
    vec[31] = mk(0, 2'b10, 2'b00, 0, 20'h4, 0, 0, 0, 0,         1, 0, 20'h4, 0, 2'b00, 2'b00, 0);
    vec[32] = mk(0, 2'b10, 2'b00, 0, 20'h4, 0, 0, 0, 0,         1, 0, 20'h4, 0, 2'b00, 2'b00, 0);
    vec[33] = mk(0, 2'b10, 2'b00, 0, 20'h4, 0, 0, 0, 0,         1, 0, 20'h4, 0, 2'b00, 2'b00, 0);
    vec[34] = mk(0, 2'b10, 2'b00, 0, 20'h4, 0, 0, 0, 0,         1, 0, 20'h4, 0, 2'b00, 2'b00, 0);
    vec[35] = mk(0, 2'b10, 2'b00, 0, 20'h4, 0, 0, 1, 32'h99,    1, 0, 20'h4, 0, 2'b10, 2'b00, 32'h99);
    vec[36] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 2'b00, 2'b00, 0);
    // reset mid-BUSY0; the next tie must go to port 0 again
    vec[37] = mk(0, 2'b01, 2'b00, 20'h5, 0, 0, 0, 0, 0,         0, 0, 0, 0, 2'b00, 2'b00, 0);
    vec[38] = mk(0, 2'b01, 2'b00, 20'h5, 0, 0, 0, 0, 0,         1, 0, 20'h5, 0, 2'b00, 2'b00, 0);
    vec[39] = mk(1, 2'b01, 2'b00, 20'h5, 0, 0, 0, 1, 32'h11,    0, 0, 0, 0, 2'b00, 2'b00, 0);
    vec[40] = mk(0, 2'b11, 2'b00, 20'h6, 20'h7, 0, 0, 0, 0,     0, 0, 0, 0, 2'b00, 2'b00, 0);
    vec[41] = mk(0, 2'b11, 2'b00, 20'h6, 20'h7, 0, 0, 1, 32'h22, 1, 0, 20'h6, 0, 2'b01, 2'b00, 32'h22);
    vec[42] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 2'b00, 2'b00, 0);

    rst = 1'b1; req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 43; i++) begin
      rst = vec[i].rst; req_valid = vec[i].v; req_rw = vec[i].rw;
      req_addr[0] = vec[i].a0; req_addr[1] = vec[i].a1;
      req_wdata[0] = vec[i].d0; req_wdata[1] = vec[i].d1;
      mem_ready = vec[i].mr; mem_rdata = vec[i].mrd;
      @(negedge clk);
      chk($sformatf("vec%0d mem_valid", i), 64'(mem_valid), 64'(vec[i].e_mv));
      chk($sformatf("vec%0d resp_ready", i), 64'(resp_ready), 64'(vec[i].e_rr));
      chk($sformatf("vec%0d resp_err", i), 64'(resp_err), 64'(vec[i].e_re));
      chk($sformatf("vec%0d resp_rdata", i), 64'(resp_rdata), 64'(vec[i].e_rd));
      if (vec[i].e_mv) begin
        chk($sformatf("vec%0d mem_rw", i), 64'(mem_rw), 64'(vec[i].e_mrw));
        chk($sformatf("vec%0d mem_addr", i), 64'(mem_addr), 64'(vec[i].e_ma));
        if (vec[i].e_mrw) chk($sformatf("vec%0d mem_wdata", i), 64'(mem_wdata), 64'(vec[i].e_mwd));
      end
      @(posedge clk); #1;
    end

    // Random traffic against the reference model.
    m_owner = -1; m_last = 1; m_elapsed = 0;
    m_rw = 1'b0; m_addr = '0; m_wdata = '0;
    need_new = 2'b11;
    req_valid = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 0) || ($urandom_range(0, 149) == 0);
      for (int p = 0; p < 2; p++) begin
        if (need_new[p] || !req_valid[p]) begin
          req_valid[p] = ($urandom_range(0, 2) != 0);
          req_rw[p]    = 1'($urandom_range(0, 1));
          req_addr[p]  = AW'($urandom);
          req_wdata[p] = $urandom;
        end else if (m_owner == p && $urandom_range(0, 7) == 0) begin
          req_valid[p] = 1'b0;
        end else if (m_owner == p && $urandom_range(0, 3) == 0) begin
          req_addr[p]  = AW'($urandom);
          req_wdata[p] = $urandom;
        end
      end
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      @(negedge clk);
      model_expect();
      chk("rand mem_valid", 64'(mem_valid), 64'(x_mv));
      chk("rand resp_ready", 64'(resp_ready), 64'(x_rr));
      chk("rand resp_err", 64'(resp_err), 64'(x_re));
      chk("rand resp_rdata", 64'(resp_rdata), 64'(x_rd));
      chk("rand resp_onehot", 64'(resp_ready == 2'b11), 64'(0));
      if (x_mv) begin
        chk("rand mem_rw", 64'(mem_rw), 64'(m_rw));
        chk("rand mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("rand mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      end
      need_new = x_rr;
      model_step();
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
